// File: rtl/gate_bist.sv
// Built-in self test for a 2-input gate: walks {A,B} through 00..11, samples Y and scores it.
// Define GATE_BIST_ERR_DIAG_EN for the error counter and first-failing-vector capture.
module gate_bist #(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1,
  parameter logic [3:0] EXP_TABLE     = 4'b0111
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_A,
  output logic       o_B,
  input  logic       i_Y,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_err_cnt,
  output logic [1:0] o_fail_vec,
  output logic       o_fail_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic [3:0] loop_cnt;
  logic [3:0] settle_cnt;
  logic       err_seen;
  logic       mismatch;
  logic       last_vec;
  logic       settle_done;

  assign mismatch    = (state == SAMPLE) && (i_Y != EXP_TABLE[vec]);
  assign last_vec    = (vec == 2'd3) && (loop_cnt == 4'(LOOPS - 1));
  assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES - 1));

  assign o_A = vec[1];
  assign o_B = vec[0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = WAIT;
      WAIT:    if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Status outputs are registered from the next state so they line up with the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      vec        <= 2'd0;
      loop_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      err_seen   <= 1'b0;
    end else begin
      o_busy <= (state_nxt == WAIT) || (state_nxt == SAMPLE);
      o_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (i_start) begin
            vec        <= 2'd0;
            loop_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            err_seen   <= 1'b0;
            o_pass     <= 1'b0;
          end
        end
        WAIT: begin
          settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
        end
        SAMPLE: begin
          err_seen   <= err_seen | mismatch;
          settle_cnt <= 4'd0;
          if (last_vec) begin
            vec    <= 2'd0;
            o_pass <= !(err_seen || mismatch);
          end else begin
            vec <= vec + 2'd1;
            if (vec == 2'd3) loop_cnt <= loop_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_BIST_ERR_DIAG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt    <= 4'd0;
      o_fail_vec   <= 2'd0;
      o_fail_valid <= 1'b0;
    end else if (state == IDLE && i_start) begin
      o_err_cnt    <= 4'd0;
      o_fail_valid <= 1'b0;
    end else if (mismatch) begin
      if (o_err_cnt != 4'd15) o_err_cnt <= o_err_cnt + 4'd1;
      if (!o_fail_valid) begin
        o_fail_vec   <= vec;
        o_fail_valid <= 1'b1;
      end
    end
  end
`else
  assign o_err_cnt    = 4'd0;
  assign o_fail_vec   = 2'd0;
  assign o_fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: each start pushes the predicted result, each o_done pops and compares it.
module tb_gate_bist;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic [1:0] fv;
    logic       fval;
  } exp_t;

  localparam logic [3:0] NAND_TT = 4'b0111;

  logic clk = 1'b0;
  logic rst, start, start8;
  logic a, b, y, busy, done, pass, fval;
  logic [3:0] err;
  logic [1:0] fv;
  logic a8, b8, y8, busy8, done8, pass8, fval8;
  logic [3:0] err8;
  logic [1:0] fv8;
  int   mode, mode8;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_bist dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_A(a), .o_B(b), .i_Y(y),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err),
    .o_fail_vec(fv), .o_fail_valid(fval)
  );

  gate_bist #(.LOOPS(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .o_A(a8), .o_B(b8), .i_Y(y8),
    .o_busy(busy8), .o_done(done8), .o_pass(pass8), .o_err_cnt(err8),
    .o_fail_vec(fv8), .o_fail_valid(fval8)
  );

  // Gate models: 0 = good NAND, 1 = stuck at 1, 2 = stuck at 0.
  function automatic logic gate(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[1] & v[0]);
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb y  = gate(mode,  {a, b});
  always_comb y8 = gate(mode8, {a8, b8});

  function automatic exp_t predict(input int m, input int loops, input int t);
    exp_t e;
    int   n;
    logic [1:0] v;
    n = 0;
    e.pass = 1'b1; e.fv = 2'd0; e.fval = 1'b0;
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < 4; i++) begin
        v = 2'(i);
        if (gate(m, v) != NAND_TT[v]) begin
          e.pass = 1'b0;
          if (n < 15) n++;
          if (!e.fval) begin e.fv = v; e.fval = 1'b1; end
        end
      end
    e.cyc = t + 4 * loops * 3 + 1;
`ifdef GATE_BIST_ERR_DIAG_EN
    e.err = 4'(n);
`else
    e.err = 4'd0; e.fv = 2'd0; e.fval = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass", pass, e.pass);
        check("err_cnt", err, e.err);
        check("fail_vec", fv, e.fv);
        check("fail_valid", fval, e.fval);
        check("busy_in_done", busy, 0);
        check("ab_in_done", {a, b}, 0);
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("done8_cycle", cyc, e.cyc);
        check("pass8", pass8, e.pass);
        check("err_cnt8", err8, e.err);
        check("fail_vec8", fv8, e.fv);
        check("fail_valid8", fval8, e.fval);
      end
    end
  end

  task automatic kick(input int m);
    mode = m;
    q.push_back(predict(m, 1, cyc));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((q.size() != 0 || q8.size() != 0) && k < 300) begin
      step();
      k++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      check({tag, "_timeout"}, 1, 0);
      q.delete();
      q8.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    int   t;
    exp_t held;
    rst = 1'b1; start = 1'b0; start8 = 1'b0; mode = 0; mode8 = 2;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_ab", {a, b}, 0);
    check("rst_err", err, 0);

    // Good NAND: vectors step 00,01,10,11 every 3 cycles.
    t = cyc;
    kick(0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) check("busy_start", busy, 1);
      if (k <= 10 && (k - 1) % 3 == 0) check("ab_step", {a, b}, (k - 1) / 3);
      step();
    end
    drain("nand");

    // Stuck at 1: only vector 11 mismatches; results hold after DONE.
    held = predict(1, 1, 0);
    kick(1);
    drain("stuck1");
    check("hold_pass", pass, held.pass);
    check("hold_err", err, held.err);
    check("hold_fail_vec", fv, held.fv);

    // Second start while running is ignored; only one o_done.
    t = cyc;
    kick(0);
    while (cyc < t + 5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    drain("restart");

    // Reset mid-run, then a fresh run.
    t = cyc;
    kick(1);
    while (cyc < t + 6) step();
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_err", err, 0);
    check("midrst_fv", {fval, fv}, 0);
    check("midrst_ab", {a, b}, 0);
    while (cyc < t + 10) step();
    kick(0);
    drain("after_rst");

    // Reset wins over start in the same cycle.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("prio_busy0", busy, 0);
    step();
    check("prio_busy1", busy, 0);

    // LOOPS=8, stuck at 0: 24 mismatches, counter saturates.
    mode8 = 2;
    q8.push_back(predict(2, 8, cyc));
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    drain("loops8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles each vector is held before Y is sampled; legal range 1..15.
REQ-002 Parameter LOOPS, default 1, number of full passes over the 4 input vectors; legal range 1..15.
REQ-003 Parameter EXP_TABLE, default 4'b0111, expected Y per vector; bit index = {A,B}; default is the 2-input NAND truth table.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  start request; sampled only in IDLE.
REQ-007 o_A  out  1  drive for the gate under test's input A.
REQ-008 o_B  out  1  drive for the gate under test's input B.
REQ-009 i_Y  in  1  output of the gate under test.
REQ-010 o_busy  out  1  high while a test sequence runs.
REQ-011 o_done  out  1  one-cycle pulse at sequence end.
REQ-012 o_pass  out  1  result of the last completed sequence; 1 = zero mismatches.
REQ-013 o_err_cnt  out  4  mismatch count of the current/last sequence.
REQ-014 o_fail_vec  out  2  {A,B} of the first mismatching vector.
REQ-015 o_fail_valid  out  1  high once o_fail_vec holds a captured value.

Function
REQ-016 FSM states IDLE, WAIT, SAMPLE, DONE; all outputs registered.
REQ-017 IDLE: i_start=1 at cycle t -> WAIT at t+1; vector v=2'b00, loop=0, settle counter=0, o_busy=1, o_pass, o_err_cnt, o_fail_valid cleared.
REQ-018 o_A=v[1], o_B=v[0] at all times; v changes only on SAMPLE->WAIT transitions.
REQ-019 WAIT lasts exactly SETTLE_CYCLES cycles, then SAMPLE for exactly one cycle; each vector occupies SETTLE_CYCLES+1 cycles.
REQ-020 SAMPLE: mismatch when i_Y != EXP_TABLE[v]; mismatch increments o_err_cnt, saturating at 15 (no wrap).
REQ-021 First mismatch of a sequence loads o_fail_vec=v and sets o_fail_valid; later mismatches leave both unchanged.
REQ-022 SAMPLE exit: v=3 and loop=LOOPS-1 -> DONE; otherwise v increments (3 wraps to 0 and loop increments) -> WAIT.
REQ-023 DONE lasts one cycle: o_done=1, o_busy=0, o_pass=1 iff no mismatch in the sequence; next state IDLE.
REQ-024 First o_done occurs at t+4*LOOPS*(SETTLE_CYCLES+1)+1; default parameters: t+13.
REQ-025 i_start ignored in WAIT, SAMPLE and DONE; i_start held high re-triggers only once IDLE is reached.
REQ-026 o_pass, o_err_cnt, o_fail_vec, o_fail_valid hold their values from DONE until the next accepted start.
REQ-027 o_A/o_B return to 0 in DONE and stay 0 in IDLE.

Reset
REQ-028 i_rst=1 at any edge, mid-sequence included, forces IDLE with o_A=0, o_B=0, o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_fail_vec=0, o_fail_valid=0 from the next cycle.
REQ-029 i_rst has priority over i_start in the same cycle; no sequence starts.

Configuration
REQ-030 Macro GATE_BIST_ERR_DIAG_EN defined: o_err_cnt, o_fail_vec, o_fail_valid behave per REQ-020/021.
REQ-031 Macro undefined: those three ports remain present and are tied to 0; o_pass is derived from a 1-bit sticky mismatch flag with unchanged timing.

Verification
REQ-032 Correct NAND on i_Y, defaults, start at t -> o_done at t+13 only, o_pass=1, o_err_cnt=0, o_fail_valid=0; o_A/o_B step 00,01,10,11 every 3 cycles.
REQ-033 i_Y stuck at 1, defaults -> o_pass=0, o_err_cnt=1, o_fail_vec=2'b11, o_fail_valid=1.
REQ-034 i_Y stuck at 0, LOOPS=8, macro defined -> 24 mismatches, o_err_cnt saturates at 15, o_fail_vec=2'b00, o_done at t+97.
REQ-035 i_start pulsed again at t+5 during a run -> ignored; single o_done at t+13.
REQ-036 i_rst at t+6 mid-run -> all outputs reset values at t+7; new start at t+10 gives o_done at t+23 with correct result.
REQ-037 Macro undefined, i_Y stuck at 1 -> o_pass=0, o_err_cnt=0, o_fail_valid=0, o_done timing unchanged.
